pipe_hazard_ctrl: RTL and testbench

- Parametrised pipeline stall/flush controller for the RISC-V core.
- Combines per-source stall requests (IF, ID, MEM, …) into a per-stage hold vector using a configurable mask per source.
- Adds sequential behaviour: a post-reset drain window, multi-cycle branch-flush sequencing, and a stall watchdog.
- Sits beside the pipeline registers; every stage register consumes one bit of each output vector.

---
 rtl/pipe_hazard_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: merges per-source stall requests into per-stage holds,
// sequences post-reset drain and branch flushes, and watches for stuck stalls.
// Optional performance counters are enabled with the macro PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
    parameter int NUM_STAGES   = 5,
    parameter int NUM_REQ      = 3,
    parameter logic [NUM_REQ*NUM_STAGES-1:0] STALL_MASK = {3{5'b11011}},
    parameter int INIT_CYCLES  = 2,
    parameter int FLUSH_CYCLES = 1,
    parameter int WDOG_LIMIT   = 1024,
    parameter int SW           = $clog2(NUM_STAGES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic [NUM_REQ-1:0]    stall_req,
    input  logic                  flush_req,
    input  logic [SW-1:0]         flush_stage,
    output logic [NUM_STAGES-1:0] stall_signal,
    output logic [NUM_STAGES-1:0] flush_signal,
    output logic                  busy,
    output logic                  stall_timeout
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    input  logic                  perf_clr,
    output logic [31:0]           perf_stall_cycles,
    output logic [31:0]           perf_flush_events
`endif
);

    localparam int CNT_MAX = (INIT_CYCLES > FLUSH_CYCLES) ? INIT_CYCLES : FLUSH_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int WW      = $clog2(WDOG_LIMIT + 1);

    localparam logic [CW-1:0] INIT_LOAD  = CW'(INIT_CYCLES - 1);
    localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_CYCLES - 1);
    localparam logic [WW-1:0] WD_MAX     = WW'(WDOG_LIMIT);
    localparam logic [SW-1:0] STAGE_MAX  = SW'(NUM_STAGES);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   fl_stage_q, fl_stage_d;
    logic [WW-1:0]   wd_cnt_q, wd_cnt_d;
    logic            timeout_d;
    logic            flush_accept;
    logic [SW-1:0]   req_stage;
    logic [NUM_STAGES-1:0] mask_or;
    logic [NUM_STAGES-1:0] fl_vec;

    always_comb begin
        mask_or = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (stall_req[i]) begin
                mask_or = mask_or | STALL_MASK[i*NUM_STAGES +: NUM_STAGES];
            end
        end
    end

    always_comb begin
        fl_vec = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            fl_vec[k] = (k < int'(fl_stage_q));
        end
    end

    assign req_stage = (flush_stage > STAGE_MAX) ? STAGE_MAX : flush_stage;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        fl_stage_d   = fl_stage_q;
        wd_cnt_d     = wd_cnt_q;
        timeout_d    = stall_timeout;
        flush_accept = 1'b0;
        if (rdy) begin
            case (state_q)
                ST_INIT: begin
                    if (cnt_q == '0) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_RUN: begin
                    if (flush_req) begin
                        state_d      = ST_FLUSH;
                        fl_stage_d   = req_stage;
                        cnt_d        = FLUSH_LOAD;
                        flush_accept = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    // A second redirect restarts the window; the deeper (older) one wins.
                    if (flush_req) begin
                        cnt_d        = FLUSH_LOAD;
                        fl_stage_d   = (req_stage > fl_stage_q) ? req_stage : fl_stage_q;
                        flush_accept = 1'b1;
                    end else if (cnt_q == '0) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = ST_INIT;
                    cnt_d   = INIT_LOAD;
                end
            endcase
            if ((state_q == ST_RUN) || (state_q == ST_FLUSH)) begin
                if (|stall_req) begin
                    if (wd_cnt_q != WD_MAX) begin
                        wd_cnt_d = wd_cnt_q + 1'b1;
                    end
                end else begin
                    wd_cnt_d = '0;
                end
                if (wd_cnt_d == WD_MAX) begin
                    timeout_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        stall_signal = mask_or;
        flush_signal = '0;
        busy         = 1'b0;
        if (rst) begin
            stall_signal = '1;
            busy         = 1'b1;
        end else begin
            case (state_q)
                ST_INIT: begin
                    stall_signal = '1;
                    busy         = 1'b1;
                end
                ST_RUN: begin
                    busy = 1'b0;
                end
                ST_FLUSH: begin
                    flush_signal = fl_vec;
                    stall_signal = mask_or & ~fl_vec;
                    busy         = 1'b1;
                end
                default: begin
                    stall_signal = '1;
                    busy         = 1'b1;
                end
            endcase
            if (!rdy) begin
                stall_signal = '1;
                flush_signal = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_INIT;
            cnt_q         <= INIT_LOAD;
            fl_stage_q    <= '0;
            wd_cnt_q      <= '0;
            stall_timeout <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            fl_stage_q    <= fl_stage_d;
            wd_cnt_q      <= wd_cnt_d;
            stall_timeout <= timeout_d;
        end
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst || perf_clr) begin
            perf_stall_cycles <= '0;
            perf_flush_events <= '0;
        end else if (rdy && ((state_q == ST_RUN) || (state_q == ST_FLUSH))) begin
            if (|stall_signal) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (flush_accept) begin
                perf_flush_events <= perf_flush_events + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: per-cycle expectations are queued by the
// driver and compared by a negedge monitor.
module tb_pipe_hazard_ctrl;

    localparam int NS = 5;
    localparam int NR = 3;
    localparam int SW = 3;
    // Distinct per-source masks so a wrong slice selection is visible.
    localparam logic [NR*NS-1:0] MASK = {5'b11011, 5'b00101, 5'b11010};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rdy = 1'b1;
    logic [NR-1:0] stall_req = '0;
    logic          flush_req = 1'b0;
    logic [SW-1:0] flush_stage = '0;
    logic [NS-1:0] stall_signal;
    logic [NS-1:0] flush_signal;
    logic          busy;
    logic          stall_timeout;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic          perf_clr = 1'b0;
    logic [31:0]   perf_stall_cycles;
    logic [31:0]   perf_flush_events;
`endif

    pipe_hazard_ctrl #(
        .NUM_STAGES  (NS),
        .NUM_REQ     (NR),
        .STALL_MASK  (MASK),
        .INIT_CYCLES (2),
        .FLUSH_CYCLES(1),
        .WDOG_LIMIT  (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .stall_req    (stall_req),
        .flush_req    (flush_req),
        .flush_stage  (flush_stage),
        .stall_signal (stall_signal),
        .flush_signal (flush_signal),
        .busy         (busy),
        .stall_timeout(stall_timeout)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        ,
        .perf_clr         (perf_clr),
        .perf_stall_cycles(perf_stall_cycles),
        .perf_flush_events(perf_flush_events)
`endif
    );

    // clock
    always #5 clk = ~clk;

    // scoreboard: {stall[11:7], flush[6:2], busy[1], timeout[0]}
    logic [11:0] exp_q[$];
    string       tag_q[$];
    int          pass_cnt  = 0;
    int          total_cnt = 0;
    logic [11:0] mon_e;
    string       mon_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            mon_t = tag_q.pop_front();
            check({mon_t, ".stall"},   32'(stall_signal),  32'(mon_e[11:7]));
            check({mon_t, ".flush"},   32'(flush_signal),  32'(mon_e[6:2]));
            check({mon_t, ".busy"},    32'(busy),          32'(mon_e[1]));
            check({mon_t, ".timeout"}, 32'(stall_timeout), 32'(mon_e[0]));
        end
    end

    // driver: one cycle of inputs plus the outputs expected during that cycle
    task automatic step(input string tag, input logic r, input logic y,
                        input logic [NR-1:0] req, input logic fr, input logic [SW-1:0] fs,
                        input logic [NS-1:0] e_stall, input logic [NS-1:0] e_flush,
                        input logic e_busy, input logic e_to);
        @(posedge clk);
        #1;
        rst         = r;
        rdy         = y;
        stall_req   = req;
        flush_req   = fr;
        flush_stage = fs;
        exp_q.push_back({e_stall, e_flush, e_busy, e_to});
        tag_q.push_back(tag);
    endtask

    initial begin
        // reset and drain window; requests in INIT are ignored
        for (int i = 0; i < 3; i++) step("rst", 1, 1, 3'b000, 0, 0, 5'b11111, 5'b00000, 1, 0);
        step("init1", 0, 1, 3'b000, 0, 0, 5'b11111, 5'b00000, 1, 0);
        step("init2", 0, 1, 3'b111, 1, 3, 5'b11111, 5'b00000, 1, 0);
        step("run0",  0, 1, 3'b000, 0, 0, 5'b00000, 5'b00000, 0, 0);

        // combinational stall masking
        step("mask2",  0, 1, 3'b100, 0, 0, 5'b11011, 5'b00000, 0, 0);
        step("mask_n", 0, 1, 3'b000, 0, 0, 5'b00000, 5'b00000, 0, 0);
        step("mask0",  0, 1, 3'b001, 0, 0, 5'b11010, 5'b00000, 0, 0);
        step("mask1",  0, 1, 3'b010, 0, 0, 5'b00101, 5'b00000, 0, 0);
        step("mask01", 0, 1, 3'b011, 0, 0, 5'b11111, 5'b00000, 0, 0);
        step("idle",   0, 1, 3'b000, 0, 0, 5'b00000, 5'b00000, 0, 0);

        // single flush, flush beats stall
        step("fl_req",  0, 1, 3'b000, 1, 3, 5'b00000, 5'b00000, 0, 0);
        step("fl_act",  0, 1, 3'b001, 0, 0, 5'b11000, 5'b00111, 1, 0);
        step("fl_done", 0, 1, 3'b000, 0, 0, 5'b00000, 5'b00000, 0, 0);

        // overlapping flushes: deeper follow-up extends and widens
        step("ov_req",  0, 1, 3'b000, 1, 2, 5'b00000, 5'b00000, 0, 0);
        step("ov_a",    0, 1, 3'b000, 1, 4, 5'b00000, 5'b00011, 1, 0);
        step("ov_b",    0, 1, 3'b000, 0, 0, 5'b00000, 5'b01111, 1, 0);
        step("ov_done", 0, 1, 3'b000, 0, 0, 5'b00000, 5'b00000, 0, 0);

        // shallower follow-up keeps the older redirect
        step("ow_req",  0, 1, 3'b000, 1, 4, 5'b00000, 5'b00000, 0, 0);
        step("ow_a",    0, 1, 3'b000, 1, 1, 5'b00000, 5'b01111, 1, 0);
        step("ow_b",    0, 1, 3'b000, 0, 0, 5'b00000, 5'b01111, 1, 0);
        step("ow_done", 0, 1, 3'b000, 0, 0, 5'b00000, 5'b00000, 0, 0);

        // flush_stage = 0 still occupies a flush cycle
        step("z_req",  0, 1, 3'b000, 1, 0, 5'b00000, 5'b00000, 0, 0);
        step("z_act",  0, 1, 3'b000, 0, 0, 5'b00000, 5'b00000, 1, 0);
        step("z_done", 0, 1, 3'b000, 0, 0, 5'b00000, 5'b00000, 0, 0);

        // out-of-range flush_stage saturates to all stages
        step("sat_req",  0, 1, 3'b000, 1, 7, 5'b00000, 5'b00000, 0, 0);
        step("sat_act",  0, 1, 3'b100, 0, 0, 5'b00000, 5'b11111, 1, 0);
        step("sat_done", 0, 1, 3'b000, 0, 0, 5'b00000, 5'b00000, 0, 0);

        // rdy low mid-flush freezes, then the flush cycle resumes
        step("rdy_req", 0, 1, 3'b000, 1, 3, 5'b00000, 5'b00000, 0, 0);
        for (int i = 0; i < 3; i++) step("rdy_frz", 0, 0, 3'b000, 0, 0, 5'b11111, 5'b00000, 1, 0);
        step("rdy_res",  0, 1, 3'b000, 0, 0, 5'b00000, 5'b00111, 1, 0);
        step("rdy_done", 0, 1, 3'b000, 0, 0, 5'b00000, 5'b00000, 0, 0);

        // reset mid-flush abandons it
        step("rm_req",   0, 1, 3'b000, 1, 3, 5'b00000, 5'b00000, 0, 0);
        step("rm_rst",   1, 1, 3'b000, 0, 0, 5'b11111, 5'b00000, 1, 0);
        step("rm_init1", 0, 1, 3'b000, 0, 0, 5'b11111, 5'b00000, 1, 0);
        step("rm_init2", 0, 1, 3'b000, 0, 0, 5'b11111, 5'b00000, 1, 0);
        step("rm_run",   0, 1, 3'b000, 0, 0, 5'b00000, 5'b00000, 0, 0);

        // watchdog: a one-cycle gap restarts the count
        for (int i = 0; i < 4; i++) step("wd_a", 0, 1, 3'b010, 0, 0, 5'b00101, 5'b00000, 0, 0);
        step("wd_gap", 0, 1, 3'b000, 0, 0, 5'b00000, 5'b00000, 0, 0);
        for (int i = 0; i < 7; i++) step("wd_b", 0, 1, 3'b010, 0, 0, 5'b00101, 5'b00000, 0, 0);
        step("wd_clr", 0, 1, 3'b000, 0, 0, 5'b00000, 5'b00000, 0, 0);

        // eight consecutive stalled cycles trip the sticky flag
        for (int i = 0; i < 8; i++) step("wd_run", 0, 1, 3'b010, 0, 0, 5'b00101, 5'b00000, 0, 0);
        step("wd_trip", 0, 1, 3'b000, 0, 0, 5'b00000, 5'b00000, 0, 1);
        for (int i = 0; i < 2; i++) step("wd_hold", 0, 1, 3'b000, 0, 0, 5'b00000, 5'b00000, 0, 1);
        step("wd_rst",   1, 1, 3'b000, 0, 0, 5'b11111, 5'b00000, 1, 1);
        step("wd_after", 0, 1, 3'b000, 0, 0, 5'b11111, 5'b00000, 1, 0);

        @(posedge clk);
        #1;
        check("drain", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
